// File: rtl/skolem_ugt_and_sched_pkg.sv
// Shared types and defaults for the (x & s) >u t Skolem scheduler.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned N_REQ_DEF = 2;

  // Index width that never collapses to zero bits.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skolem_ugt_and_sched_if.sv
// Request/response bundle between the solver front-end and the scheduler.
interface skolem_ugt_and_sched_if #(
  parameter int unsigned W     = skolem_pkg::W_DEF,
  parameter int unsigned N_REQ = skolem_pkg::N_REQ_DEF
);
  import skolem_pkg::*;

  localparam int unsigned ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_s;
  logic [N_REQ*W-1:0] req_t;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_x;
  logic               rsp_sat;

  modport master (
    output req_valid, req_s, req_t, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_sat
  );

  modport slave (
    input  req_valid, req_s, req_t, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_sat
  );

endinterface

// File: rtl/skolem_ugt_and_sched_bit.sv
// One MSB-first step of the Skolem witness for (x & s) >u t plus its serial compare.
module skolem_ugt_and_bit (
  input  logic s_k,
  input  logic t_k,
  input  logic eq_in,
  input  logic gt_in,
  output logic x_k,
  output logic eq_out,
  output logic gt_out
);

  logic w_a;

  // Choosing x = s maximises x & s, so it is a witness whenever one exists.
  assign x_k    = s_k;
  assign w_a    = x_k & s_k;
  assign gt_out = gt_in | (eq_in & w_a & ~t_k);
  assign eq_out = eq_in & (w_a == t_k);

endmodule

// File: rtl/skolem_ugt_and_sched.sv
// Round-robin front end sharing one serial Skolem evaluator among N_REQ requesters.
module skolem_ugt_and_sched #(
  parameter int unsigned W     = skolem_pkg::W_DEF,
  parameter int unsigned N_REQ = skolem_pkg::N_REQ_DEF
) (
  input logic                    clk,
  input logic                    rst,
  skolem_ugt_and_sched_if.slave  sched
);
  import skolem_pkg::*;

  localparam int unsigned     ID_W    = id_width(N_REQ);
  localparam int unsigned     K_W     = id_width(W);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);
  localparam logic [K_W-1:0]  K_TOP   = K_W'(W - 1);

  sched_state_t     r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [W-1:0]     r_s;
  logic [W-1:0]     r_t;
  logic [W-1:0]     r_x;
  logic             r_eq;
  logic             r_gt;
  logic [K_W-1:0]   r_k;
  logic             r_rsp_valid;
  logic [W-1:0]     r_rsp_x;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_sat;

  logic [N_REQ-1:0] w_grant_oh;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_grant_any;
  logic [W-1:0]     w_sel_s;
  logic [W-1:0]     w_sel_t;
  logic             w_s_k;
  logic             w_t_k;
  logic             w_x_k;
  logic             w_eq_nxt;
  logic             w_gt_nxt;
  logic [W-1:0]     w_x_nxt;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p,
                                             input int unsigned off);
    return ID_W'((32'(p) + off) % N_REQ);
  endfunction

  // Search starts just after the last grant, so the previous winner goes last.
  always_comb begin
    w_grant_oh  = '0;
    w_grant_id  = '0;
    w_grant_any = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      if (!w_grant_any && sched.req_valid[rr_idx(r_ptr, off)]) begin
        w_grant_any = 1'b1;
        w_grant_id  = rr_idx(r_ptr, off);
      end
    end
    if (w_grant_any) begin
      w_grant_oh[w_grant_id] = 1'b1;
    end
  end

  assign sched.req_ready = (r_state == IDLE) ? w_grant_oh : '0;

  assign w_sel_s = sched.req_s[32'(w_grant_id) * W +: W];
  assign w_sel_t = sched.req_t[32'(w_grant_id) * W +: W];

  assign w_s_k = r_s[r_k];
  assign w_t_k = r_t[r_k];

  skolem_ugt_and_bit u_bit (
    .s_k    (w_s_k),
    .t_k    (w_t_k),
    .eq_in  (r_eq),
    .gt_in  (r_gt),
    .x_k    (w_x_k),
    .eq_out (w_eq_nxt),
    .gt_out (w_gt_nxt)
  );

  always_comb begin
    w_x_nxt      = r_x;
    w_x_nxt[r_k] = w_x_k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= PTR_RST;
      r_id        <= '0;
      r_s         <= '0;
      r_t         <= '0;
      r_x         <= '0;
      r_eq        <= 1'b1;
      r_gt        <= 1'b0;
      r_k         <= K_TOP;
      r_rsp_valid <= 1'b0;
      r_rsp_x     <= '0;
      r_rsp_id    <= '0;
      r_rsp_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_s     <= w_sel_s;
            r_t     <= w_sel_t;
            r_id    <= w_grant_id;
            r_ptr   <= w_grant_id;
            r_x     <= '0;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_k     <= K_TOP;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_x  <= w_x_nxt;
          r_eq <= w_eq_nxt;
          r_gt <= w_gt_nxt;
          r_k  <= r_k - K_W'(1);
          // Last bit: publish the final witness and flag directly from this cycle.
          if (r_k == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_x     <= w_x_nxt;
            r_rsp_id    <= r_id;
            r_rsp_sat   <= w_gt_nxt;
          end
        end
        RESP: begin
          if (sched.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sched.rsp_valid = r_rsp_valid;
  assign sched.rsp_x     = r_rsp_x;
  assign sched.rsp_id    = r_rsp_id;
  assign sched.rsp_sat   = r_rsp_sat;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(sched.req_ready));

endmodule
